// File: rtl/glb_pe_mc.sv
// glb_pe_mc: global-bus processing element with (row,col) tag filtering,
// column broadcast, ifmap/weight FIFOs, a multi-tap signed MAC and a
// valid/ready psum chain stage.
// Optional build macro GLB_PE_PSUM_SAT_EN: saturating accumulate/psum add
// plus a sticky sat_flag output; without it arithmetic wraps.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The bus side drops unmatched packets (ready=1, no push).
// psum_out_valid holds, with data stable, until psum_out_ready is seen.
// dbg_state exposes the FSM state (0 IDLE, 1 MAC, 2 WAIT_PSUM, 3 OUT).
module glb_pe_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int PSUM_WIDTH = 40,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_TAPS   = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ID_WIDTH-1:0]             cfg_row_id,
  input  logic [ID_WIDTH-1:0]             cfg_col_id,
  input  logic [$clog2(MAX_TAPS+1)-1:0]   cfg_taps,
  input  logic                            bus_valid,
  output logic                            bus_ready,
  input  logic                            bus_type,
  input  logic [ID_WIDTH-1:0]             bus_row_tag,
  input  logic [ID_WIDTH-1:0]             bus_col_tag,
  input  logic [DATA_WIDTH-1:0]           bus_data,
  input  logic                            psum_in_valid,
  output logic                            psum_in_ready,
  input  logic [PSUM_WIDTH-1:0]           psum_in_data,
  output logic                            psum_out_valid,
  input  logic                            psum_out_ready,
  output logic [PSUM_WIDTH-1:0]           psum_out_data,
  output logic                            busy,
  output logic [1:0]                      dbg_state
`ifdef GLB_PE_PSUM_SAT_EN
  ,
  output logic                            sat_flag
`endif
);

  localparam int TAP_W  = $clog2(MAX_TAPS+1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int PROD_W = 2*DATA_WIDTH;
  localparam int MSB    = PSUM_WIDTH-1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] ifm_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wgt_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      ifm_wr, ifm_rd, wgt_wr, wgt_rd;
  logic [PTR_W:0]        ifm_cnt, wgt_cnt;
  logic                  ifm_full, wgt_full, ifm_empty, wgt_empty;
  logic                  match, sel_full, ifm_push, wgt_push, pop, start, last_pop;

  logic [PSUM_WIDTH-1:0] acc;
  logic [TAP_W-1:0]      tap_cnt, taps_q, tap_cnt_inc;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PSUM_WIDTH-1:0] prod_ext;
  logic [PSUM_WIDTH-1:0] acc_wrap, out_wrap, acc_next, out_next;

  assign ifm_full  = (ifm_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign wgt_full  = (wgt_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign ifm_empty = (ifm_cnt == '0);
  assign wgt_empty = (wgt_cnt == '0);

  // Tag filter: own (row,col) or own row with the all-ones column broadcast.
  assign match    = (bus_row_tag == cfg_row_id) &&
                    ((bus_col_tag == cfg_col_id) || (bus_col_tag == {ID_WIDTH{1'b1}}));
  // Full flag is the registered (pre-pop) one: no same-cycle bypass.
  assign sel_full  = bus_type ? wgt_full : ifm_full;
  assign bus_ready = !rst && (!match || !sel_full);
  assign ifm_push  = bus_valid && bus_ready && match && !bus_type;
  assign wgt_push  = bus_valid && bus_ready && match && bus_type;

  assign start       = (cfg_taps != '0) && !ifm_empty && !wgt_empty;
  assign pop         = (state_q == S_MAC) && !ifm_empty && !wgt_empty;
  assign tap_cnt_inc = tap_cnt + TAP_W'(1);
  assign last_pop    = pop && (tap_cnt_inc == taps_q);

  // Full-precision signed product, sign-extended to the accumulator width.
  assign prod     = $signed(ifm_mem[ifm_rd]) * $signed(wgt_mem[wgt_rd]);
  assign prod_ext = PSUM_WIDTH'(prod);
  assign acc_wrap = acc + prod_ext;
  assign out_wrap = acc + psum_in_data;

`ifdef GLB_PE_PSUM_SAT_EN
  localparam logic [PSUM_WIDTH-1:0] PS_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] PS_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  logic acc_clip, out_clip;
  // Overflow only when both operands share a sign the wrapped sum lost.
  assign acc_clip = (acc[MSB] == prod_ext[MSB]) && (acc_wrap[MSB] != acc[MSB]);
  assign out_clip = (acc[MSB] == psum_in_data[MSB]) && (out_wrap[MSB] != acc[MSB]);
  assign acc_next = acc_clip ? (acc[MSB] ? PS_MIN : PS_MAX) : acc_wrap;
  assign out_next = out_clip ? (acc[MSB] ? PS_MIN : PS_MAX) : out_wrap;
`else
  assign acc_next = acc_wrap;
  assign out_next = out_wrap;
`endif

  // FIFO pointers and occupancy; reset flushes both FIFOs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifm_wr  <= '0;
      ifm_rd  <= '0;
      ifm_cnt <= '0;
      wgt_wr  <= '0;
      wgt_rd  <= '0;
      wgt_cnt <= '0;
    end else begin
      if (ifm_push) ifm_wr <= ifm_wr + PTR_W'(1);
      if (wgt_push) wgt_wr <= wgt_wr + PTR_W'(1);
      if (pop) begin
        ifm_rd <= ifm_rd + PTR_W'(1);
        wgt_rd <= wgt_rd + PTR_W'(1);
      end
      ifm_cnt <= ifm_cnt + (PTR_W+1)'(ifm_push) - (PTR_W+1)'(pop);
      wgt_cnt <= wgt_cnt + (PTR_W+1)'(wgt_push) - (PTR_W+1)'(pop);
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (ifm_push) ifm_mem[ifm_wr] <= bus_data;
    if (wgt_push) wgt_mem[wgt_wr] <= bus_data;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)          state_d = S_MAC;
      S_MAC:   if (last_pop)       state_d = S_WAIT;
      S_WAIT:  if (psum_in_valid)  state_d = S_OUT;
      S_OUT:   if (psum_out_ready) state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state.
  always_comb begin
    psum_in_ready  = (state_q == S_WAIT);
    psum_out_valid = (state_q == S_OUT);
    busy           = (state_q != S_IDLE);
    dbg_state      = state_q;
  end

  // Datapath: job latch, accumulation and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      tap_cnt       <= '0;
      taps_q        <= '0;
      psum_out_data <= '0;
`ifdef GLB_PE_PSUM_SAT_EN
      sat_flag      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          taps_q  <= cfg_taps;
          tap_cnt <= '0;
          acc     <= '0;
`ifdef GLB_PE_PSUM_SAT_EN
          sat_flag <= 1'b0;
`endif
        end
        S_MAC: if (pop) begin
          acc     <= acc_next;
          tap_cnt <= tap_cnt_inc;
`ifdef GLB_PE_PSUM_SAT_EN
          if (acc_clip) sat_flag <= 1'b1;
`endif
        end
        S_WAIT: if (psum_in_valid) begin
          psum_out_data <= out_next;
`ifdef GLB_PE_PSUM_SAT_EN
          if (out_clip) sat_flag <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_pe_mc.sv
// Testbench for glb_pe_mc (PSUM_WIDTH=32 so wrap/saturate corners are easy
// to reach). Stimulus tasks push the model's expected result into exp_q; an
// independent monitor pops and compares on every psum_out transfer.
module tb_glb_pe_mc;
  localparam int DW = 16;
  localparam int PW = 32;
  localparam int IW = 4;
  localparam int FD = 4;
  localparam int MT = 16;
  localparam int TW = $clog2(MT+1);

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] cfg_row_id, cfg_col_id;
  logic [TW-1:0] cfg_taps;
  logic          bus_valid, bus_ready, bus_type;
  logic [IW-1:0] bus_row_tag, bus_col_tag;
  logic [DW-1:0] bus_data;
  logic          psum_in_valid, psum_in_ready;
  logic [PW-1:0] psum_in_data;
  logic          psum_out_valid, psum_out_ready;
  logic [PW-1:0] psum_out_data;
  logic          busy;
  logic [1:0]    dbg_state;
`ifdef GLB_PE_PSUM_SAT_EN
  logic          sat_flag;
`endif

  always #5 clk = ~clk;

  glb_pe_mc #(
    .DATA_WIDTH(DW), .PSUM_WIDTH(PW), .ID_WIDTH(IW), .FIFO_DEPTH(FD), .MAX_TAPS(MT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_row_id(cfg_row_id), .cfg_col_id(cfg_col_id), .cfg_taps(cfg_taps),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_type(bus_type),
    .bus_row_tag(bus_row_tag), .bus_col_tag(bus_col_tag), .bus_data(bus_data),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready), .psum_out_data(psum_out_data),
    .busy(busy), .dbg_state(dbg_state)
`ifdef GLB_PE_PSUM_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [PW-1:0] exp_q[$];
  bit            exp_sat_q[$];
  int            n_cmp  = 0;
  int            n_fail = 0;
  longint        job_ifm[MT];
  longint        job_wt[MT];
  bit            model_sat;
  bit            rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

`ifdef GLB_PE_PSUM_SAT_EN
  function automatic longint clamp(input longint v);
    longint hi = (longint'(1) <<< (PW-1)) - 1;
    longint lo = -(longint'(1) <<< (PW-1));
    if (v > hi) begin model_sat = 1'b1; return hi; end
    if (v < lo) begin model_sat = 1'b1; return lo; end
    return v;
  endfunction
`endif

  // Reference: dot product of the job vectors plus the upstream psum, using
  // plain 64-bit integers; the result is reduced to PW bits at the end (wrap)
  // or clamped after every addition (saturating build).
  function automatic logic [PW-1:0] model(input int taps, input longint pin);
    longint acc = 0;
    model_sat = 1'b0;
    for (int i = 0; i < taps; i++) begin
      acc = acc + job_ifm[i] * job_wt[i];
`ifdef GLB_PE_PSUM_SAT_EN
      acc = clamp(acc);
`endif
    end
    acc = acc + pin;
`ifdef GLB_PE_PSUM_SAT_EN
    acc = clamp(acc);
`endif
    return acc[PW-1:0];
  endfunction

  task automatic expect_job(input int taps, input longint pin);
    exp_q.push_back(model(taps, pin));
    exp_sat_q.push_back(model_sat);
  endtask

  // ---------------- monitor ----------------
  // Compares every accepted result against the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [PW-1:0] e;
    bit            es;
    if (!rst && psum_out_valid && psum_out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", psum_out_valid, 1'b0);
      end else begin
        e  = exp_q.pop_front();
        es = exp_sat_q.pop_front();
        check("psum_out_data", psum_out_data, e);
`ifdef GLB_PE_PSUM_SAT_EN
        check("sat_flag", sat_flag, es);
`endif
      end
    end
  end

  // Random downstream backpressure for the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      psum_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- drivers ----------------
  task automatic bus_send(input bit typ, input logic [IW-1:0] row, input logic [IW-1:0] col,
                          input logic [DW-1:0] data, input bit chk_ready);
    int w = 0;
    bus_valid = 1'b1; bus_type = typ; bus_row_tag = row; bus_col_tag = col; bus_data = data;
    @(negedge clk);
    if (chk_ready) check("bus_ready_accept", bus_ready, 1'b1);
    while (!bus_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!bus_ready) check("bus_send_timeout", bus_ready, 1'b1);
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
  endtask

  task automatic psum_send(input longint v);
    int w = 0;
    psum_in_valid = 1'b1;
    psum_in_data  = v[PW-1:0];
    @(negedge clk);
    while (!psum_in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!psum_in_ready) check("psum_send_timeout", psum_in_ready, 1'b1);
    @(posedge clk);
    #1;
    psum_in_valid = 1'b0;
  endtask

  task automatic send_noise();
    logic [IW-1:0] r, c;
    do begin
      r = IW'($urandom_range(0, 15));
      c = IW'($urandom_range(0, 15));
    end while (r == 4'd2 && (c == 4'd1 || c == 4'd15));
    bus_send(1'($urandom_range(0, 1)), r, c, DW'($urandom), 1'b1);
  endtask

  task automatic run_job(input int taps, input longint pin, input bit noise);
    logic [IW-1:0] col;
    cfg_taps = TW'(taps);
    expect_job(taps, pin);
    for (int i = 0; i < taps; i++) begin
      if (noise && $urandom_range(0, 3) == 0) send_noise();
      col = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd15;
      bus_send(1'b0, 4'd2, col, job_ifm[i][DW-1:0], 1'b0);
      col = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'd15;
      bus_send(1'b1, 4'd2, col, job_wt[i][DW-1:0], 1'b0);
    end
    psum_send(pin);
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int w;
    logic [DW-1:0] r16;
    logic [PW-1:0] r32;

    rst = 1'b1;
    cfg_row_id = 4'd2; cfg_col_id = 4'd1; cfg_taps = '0;
    bus_valid = 1'b0; bus_type = 1'b0; bus_row_tag = 4'd7; bus_col_tag = 4'd7; bus_data = '0;
    psum_in_valid = 1'b0; psum_in_data = '0; psum_out_ready = 1'b1;

    // Reset values (unmatched tag on the bus: ready is forced low by rst alone).
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus_ready", bus_ready, 1'b0);
    check("rst_psum_in_ready", psum_in_ready, 1'b0);
    check("rst_psum_out_valid", psum_out_valid, 1'b0);
    check("rst_psum_out_data", psum_out_data, '0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Tag filter: only (2,1) and broadcast (2,15) land in the ifmap FIFO.
    cfg_taps = TW'(2);
    job_ifm[0] = 11; job_ifm[1] = -4; job_wt[0] = 3; job_wt[1] = 9;
    expect_job(2, 100);
    bus_send(1'b0, 4'd2, 4'd1, 16'd11, 1'b1);
    bus_send(1'b1, 4'd2, 4'd1, 16'd3, 1'b1);
    bus_send(1'b0, 4'd2, 4'd3, 16'd777, 1'b1);
    bus_send(1'b0, 4'd3, 4'd1, 16'd555, 1'b1);
    bus_send(1'b0, 4'd2, 4'd15, 16'hFFFC, 1'b1);
    bus_send(1'b1, 4'd2, 4'd1, 16'd9, 1'b1);
    psum_send(100);
    wait_drain();

    // Basic MAC with latency: preload while disabled, then enable.
    cfg_taps = '0;
    for (int i = 0; i < 3; i++) begin
      job_ifm[i] = i + 1;
      job_wt[i]  = i + 4;
      bus_send(1'b0, 4'd2, 4'd1, job_ifm[i][DW-1:0], 1'b1);
      bus_send(1'b1, 4'd2, 4'd1, job_wt[i][DW-1:0], 1'b1);
    end
    repeat (2) @(posedge clk);
    #1;
    check("taps0_idle_busy", busy, 1'b0);
    expect_job(3, 10);
    psum_in_valid = 1'b1;
    psum_in_data  = 32'd10;
    cfg_taps = TW'(3);
    @(posedge clk);  // IDLE -> MAC; the next cycle is the first pop
    cyc = 0;
    while (!psum_out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    psum_in_valid = 1'b0;
    check("latency_first_pop_to_valid", cyc, 4);
    wait_drain();

    // Signed operands.
    job_ifm[0] = -3; job_wt[0] = 7;
    run_job(1, -5, 1'b0);
    wait_drain();

    // Wrap / saturate corner.
    job_ifm[0] = 32767; job_wt[0] = 32767;
    run_job(1, 64'sd2147483647, 1'b0);
    wait_drain();

    // Backpressure: full weight FIFO refuses a matched weight, ifmap still accepted.
    cfg_taps = '0;
    for (int i = 0; i < 4; i++) begin
      job_wt[i] = i + 2;
      bus_send(1'b1, 4'd2, 4'd1, job_wt[i][DW-1:0], 1'b1);
    end
    bus_valid = 1'b1; bus_type = 1'b1; bus_row_tag = 4'd2; bus_col_tag = 4'd1; bus_data = 16'd99;
    @(negedge clk);
    check("full_weight_ready", bus_ready, 1'b0);
    bus_col_tag = 4'd15;
    @(negedge clk);
    check("full_weight_bcast_ready", bus_ready, 1'b0);
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      job_ifm[i] = 10 * i - 7;
      bus_send(1'b0, 4'd2, 4'd1, job_ifm[i][DW-1:0], 1'b1);
    end
    psum_out_ready = 1'b0;
    cfg_taps = TW'(4);
    expect_job(4, 1234);
    psum_send(1234);
    w = 0;
    while (!psum_out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("bp_valid_rise", psum_out_valid, 1'b1);
    // Queue a second job while the first is stalled in OUT.
    cfg_taps = TW'(1);
    job_ifm[0] = 6; job_wt[0] = -8;
    expect_job(1, 50);
    bus_send(1'b0, 4'd2, 4'd1, 16'd6, 1'b1);
    bus_send(1'b1, 4'd2, 4'd1, 16'hFFF8, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", psum_out_valid, 1'b1);
      check("bp_hold_data", psum_out_data, exp_q[0]);
    end
    psum_out_ready = 1'b1;
    psum_send(50);
    wait_drain();

    // Reset mid-job: 2 of 4 taps consumed, weight FIFO starved.
    cfg_taps = '0;
    for (int i = 0; i < 4; i++) bus_send(1'b0, 4'd2, 4'd1, DW'(10 * (i + 1)), 1'b1);
    for (int i = 0; i < 2; i++) bus_send(1'b1, 4'd2, 4'd1, DW'(i + 1), 1'b1);
    bus_row_tag = 4'd7;
    cfg_taps = TW'(4);
    repeat (3) @(posedge clk);
    #1;
    check("mid_job_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_bus_ready", bus_ready, 1'b0);
    check("abort_psum_in_ready", psum_in_ready, 1'b0);
    check("abort_psum_out_valid", psum_out_valid, 1'b0);
    check("abort_psum_out_data", psum_out_data, '0);
    check("abort_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    check("abort_busy_after_edge", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    job_ifm[0] = 5; job_wt[0] = 6;
    run_job(1, 7, 1'b0);
    wait_drain();

    // Random jobs with tag noise and downstream backpressure.
    rand_ready = 1'b1;
    for (int j = 0; j < 25; j++) begin
      int taps;
      taps = $urandom_range(1, MT);
      for (int i = 0; i < taps; i++) begin
        r16 = DW'($urandom);
        job_ifm[i] = longint'($signed(r16));
        r16 = DW'($urandom);
        job_wt[i] = longint'($signed(r16));
      end
      r32 = PW'($urandom);
      run_job(taps, longint'($signed(r32)), 1'b1);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    psum_out_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
